// File: rtl/ecc_pkg.sv
// Field constants, conversion FSM states and the modular helper that the
// Ed25519 projective-to-affine path and its multiplier share.
package ecc_pkg;

    localparam int WIDTH = 256;
    localparam logic [WIDTH-1:0] P =
        256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFED;
    localparam logic [WIDTH-1:0] P_MINUS_2 = P - 256'd2;

    // The multiplier consumes MUL_BITS bits of its second operand per cycle.
    localparam int MUL_BITS = 128;
    localparam int MUL_LAT  = WIDTH / MUL_BITS;
    localparam int CNT_W    = $clog2(MUL_LAT + 1);

    // Bit 254 of P-2 is absorbed by seeding the accumulator with Z.
    localparam logic [7:0] EXP_TOP = 8'd253;

    typedef enum logic [2:0] {
        IDLE,
        CHKZ,
        SQR,
        MUL,
        MULX,
        MULY,
        DONE
    } state_t;

    // MSB-first interleaved step: acc = 2*acc + bit*a, kept fully reduced.
    function automatic logic [WIDTH-1:0] mul_chunk(
        input logic [WIDTH-1:0]    acc,
        input logic [WIDTH-1:0]    a,
        input logic [MUL_BITS-1:0] bits
    );
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] r;
        r = acc;
        for (int i = MUL_BITS - 1; i >= 0; i--) begin
            t = {r, 1'b0};
            if (t >= {1'b0, P}) t = t - {1'b0, P};
            r = t[WIDTH-1:0];
            if (bits[i]) begin
                t = {1'b0, r} + {1'b0, a};
                if (t >= {1'b0, P}) t = t - {1'b0, P};
                r = t[WIDTH-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/modmul_p25519.sv
// Sequential interleaved shift-add multiplier mod 2^255-19 with a fixed
// latency of MUL_LAT cycles from i_start to the o_done pulse.
module modmul_p25519
    import ecc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r,
    output logic             o_done
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // The first chunk is folded into the start cycle so latency stays MUL_LAT.
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (i_start) begin
            a_d   = i_a;
            acc_d = mul_chunk({WIDTH{1'b0}}, i_a, i_b[WIDTH-1 -: MUL_BITS]);
            b_d   = i_b << MUL_BITS;
            cnt_d = CNT_W'(MUL_LAT - 1);
        end else if (cnt_q != '0) begin
            acc_d  = mul_chunk(acc_q, a_q, b_q[WIDTH-1 -: MUL_BITS]);
            b_d    = b_q << MUL_BITS;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_r    = acc_q;
    assign o_done = done_q;

endmodule

// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (x, y) over GF(2^255-19): Z^-1 = Z^(p-2) by
// left-to-right square-and-multiply, then x = X*Z^-1 and y = Y*Z^-1.
module proj_to_affine
    import ecc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_z,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_error
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0] o_x_q, o_x_d, o_y_q, o_y_d;
    logic [7:0]       k_q, k_d;
    logic             mul_start_q, mul_start_d;
    logic             busy_q, busy_d, finished_q, finished_d, error_q, error_d;
    logic [WIDTH-1:0] mul_r;
    logic             mul_done;

    modmul_p25519 u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (mul_start_q),
        .i_a     (mul_a_q),
        .i_b     (mul_b_q),
        .o_r     (mul_r),
        .o_done  (mul_done)
    );

    // Each multiplier op is launched on the transition into its state, so
    // every op costs MUL_LAT+1 cycles with no idle gap between ops.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        acc_d       = acc_q;
        k_d         = k_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        o_x_d       = o_x_q;
        o_y_d       = o_y_q;
        busy_d      = busy_q;
        finished_d  = 1'b0;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    z_d     = i_z;
                    acc_d   = i_z;
                    k_d     = EXP_TOP;
                    busy_d  = 1'b1;
                    state_d = CHKZ;
                end
            end
            CHKZ: begin
                if (z_q == '0) begin
                    o_x_d      = '0;
                    o_y_d      = '0;
                    error_d    = 1'b1;
                    finished_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else begin
                    mul_a_d     = acc_q;
                    mul_b_d     = acc_q;
                    mul_start_d = 1'b1;
                    state_d     = SQR;
                end
            end
            SQR: begin
                if (mul_done) begin
                    acc_d       = mul_r;
                    mul_start_d = 1'b1;
                    if (P_MINUS_2[k_q]) begin
                        mul_a_d = mul_r;
                        mul_b_d = z_q;
                        state_d = MUL;
                    end else if (k_q == 8'd0) begin
                        mul_a_d = x_q;
                        mul_b_d = mul_r;
                        state_d = MULX;
                    end else begin
                        mul_a_d = mul_r;
                        mul_b_d = mul_r;
                        k_d     = k_q - 8'd1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    acc_d       = mul_r;
                    mul_start_d = 1'b1;
                    if (k_q == 8'd0) begin
                        mul_a_d = x_q;
                        mul_b_d = mul_r;
                        state_d = MULX;
                    end else begin
                        mul_a_d = mul_r;
                        mul_b_d = mul_r;
                        k_d     = k_q - 8'd1;
                        state_d = SQR;
                    end
                end
            end
            MULX: begin
                if (mul_done) begin
                    o_x_d       = mul_r;
                    mul_a_d     = y_q;
                    mul_b_d     = acc_q;
                    mul_start_d = 1'b1;
                    state_d     = MULY;
                end
            end
            MULY: begin
                if (mul_done) begin
                    o_y_d      = mul_r;
                    error_d    = 1'b0;
                    finished_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            o_x_q       <= '0;
            o_y_q       <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            o_x_q       <= o_x_d;
            o_y_q       <= o_y_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
        end
    end

    assign o_x        = o_x_q;
    assign o_y        = o_y_q;
    assign o_busy     = busy_q;
    assign o_finished = finished_q;
    assign o_error    = error_q;

endmodule
